// File: rtl/key_schedule_engine.sv
`default_nettype none
// ============================================================================
//  Module      : key_schedule_engine
//  Description : Sequential AES key expansion for 128/192/256-bit keys.
//                Builds the word schedule one 32-bit word per push, using a
//                registered (one-cycle) SubWord lookup. Streams the Nr+1
//                128-bit round keys over a valid/ready handshake.
//  Ports       : clk       - system clock, rising edge
//                reset     - asynchronous active-high reset
//                start     - begin a new expansion (sampled in IDLE only)
//                key       - cipher key, key[KEY_BITS-1 -: 32] is w[0]
//                busy      - expansion in progress
//                rkValid   - roundKey / rkRound / rkLast valid
//                rkReady   - consumer accepts the presented round key
//                roundKey  - {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//                rkRound   - round index r, 0..Nr
//                rkLast    - presented key is round Nr
//                done      - one-cycle pulse after the final transfer
//  Revision    : 1.0 - initial release
// ============================================================================
module key_schedule_engine #(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [KEY_BITS-1:0] key,
   output logic                busy,
   output logic                rkValid,
   input  logic                rkReady,
   output logic [127:0]        roundKey,
   output logic [3:0]          rkRound,
   output logic                rkLast,
   output logic                done
);

   localparam int         NK       = KEY_BITS / 32;
   localparam int         NR       = NK + 6;
   localparam logic [5:0] WORDS    = 6'(4 * (NR + 1));
   localparam logic [5:0] NK_IDX   = 6'(NK);
   localparam logic [2:0] NK_LAST  = 3'(NK - 1);
   localparam logic [3:0] NR_ROUND = 4'(NR);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PUSH = 3'd1,
      SUB  = 3'd2,
      GEN  = 3'd3,
      DONE = 3'd4
   } state_t;

   // ------------------------------------------------------------------------
   // GF(2^8) arithmetic for the S-box: inverse via x^254, then affine map.
   // ------------------------------------------------------------------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_byte(input logic [7:0] x);
      logic [7:0] x3, x7, x15, x31, x63, x127, inv;
      x3   = gf_mul(gf_mul(x, x), x);
      x7   = gf_mul(gf_mul(x3, x3), x);
      x15  = gf_mul(gf_mul(x7, x7), x);
      x31  = gf_mul(gf_mul(x15, x15), x);
      x63  = gf_mul(gf_mul(x31, x31), x);
      x127 = gf_mul(gf_mul(x63, x63), x);
      inv  = gf_mul(x127, x127);   // x^254 == x^-1, and maps 0 to 0
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox_byte(w[31:24]), sbox_byte(w[23:16]),
              sbox_byte(w[15:8]),  sbox_byte(w[7:0])};
   endfunction

   // A generated word needs SubWord at i mod Nk == 0, plus i mod 8 == 4 for AES-256.
   function automatic logic needs_sub(input logic [5:0] i, input logic [2:0] m);
      return (i >= NK_IDX) && (i < WORDS) &&
             ((m == 3'd0) || ((NK == 8) && (m == 3'd4)));
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t      state;
   logic [31:0] win [NK];     // win[0] = w[i-Nk] ... win[NK-1] = w[i-1]
   logic [5:0]  idx;          // index i of the next word to push
   logic [2:0]  wmod;         // i mod Nk
   logic [7:0]  rcon;
   logic [31:0] sbox_q;       // registered SubWord result
   logic [95:0] asm_q;        // first three words of the round key in progress
   logic [1:0]  fill;
   logic [3:0]  round_cnt;

   logic        stalled;
   logic        xfer;
   logic        cur_sub;
   logic        nxt_sub;
   logic        do_push;
   logic [5:0]  idx_nx;
   logic [2:0]  mod_nx;
   logic [31:0] prev_word;
   logic [31:0] sub_addr;
   logic [31:0] push_word;

   always_comb begin
      stalled   = rkValid && !rkReady;
      xfer      = rkValid && rkReady;
      idx_nx    = idx + 6'd1;
      mod_nx    = (wmod == NK_LAST) ? 3'd0 : wmod + 3'd1;
      cur_sub   = needs_sub(idx, wmod);
      nxt_sub   = needs_sub(idx_nx, mod_nx);
      prev_word = win[NK-1];
      sub_addr  = (wmod == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
      do_push   = 1'b0;
      push_word = win[0] ^ prev_word;
      case (state)
         PUSH: begin
            if ((idx != WORDS) && !stalled) begin
               if (idx < NK_IDX) begin
                  // Key words: the window is rotated, so w[i] is always win[0]
                  // and the window is back in order once all Nk are pushed.
                  do_push   = 1'b1;
                  push_word = win[0];
               end else if (!cur_sub) begin
                  do_push = 1'b1;
               end
            end
         end
         GEN: begin
            if (!stalled) begin
               do_push   = 1'b1;
               push_word = win[0] ^ sbox_q ^ ((wmod == 3'd0) ? {rcon, 24'h0} : 32'h0);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         rkValid   <= 1'b0;
         roundKey  <= '0;
         rkRound   <= '0;
         rkLast    <= 1'b0;
         done      <= 1'b0;
         for (int j = 0; j < NK; j++) win[j] <= '0;
         idx       <= '0;
         wmod      <= '0;
         rcon      <= 8'h01;
         sbox_q    <= '0;
         asm_q     <= '0;
         fill      <= '0;
         round_cnt <= '0;
      end else begin
         done <= 1'b0;
         if (xfer) begin
            rkValid <= 1'b0;
            rkLast  <= 1'b0;
         end

         if (do_push) begin
            for (int j = 0; j < NK - 1; j++) win[j] <= win[j+1];
            win[NK-1] <= push_word;
            idx       <= idx_nx;
            wmod      <= mod_nx;
            asm_q     <= {asm_q[63:0], push_word};
            fill      <= fill + 2'd1;   // wraps to 0 on the fourth word
            // A push can coincide with a transfer only as word 0, so setting
            // rkValid here never collides with the drop above.
            if (fill == 2'd3) begin
               roundKey  <= {asm_q, push_word};
               rkValid   <= 1'b1;
               rkRound   <= round_cnt;
               rkLast    <= (round_cnt == NR_ROUND);
               round_cnt <= round_cnt + 4'd1;
            end
         end

         case (state)
            IDLE: begin
               if (start) begin
                  for (int j = 0; j < NK; j++) win[j] <= key[KEY_BITS-1-32*j -: 32];
                  idx       <= '0;
                  wmod      <= '0;
                  rcon      <= 8'h01;
                  fill      <= '0;
                  round_cnt <= '0;
                  busy      <= 1'b1;
                  state     <= PUSH;
               end
            end
            PUSH: begin
               if (idx == WORDS) begin
                  // Every word pushed: wait for the last round key to leave.
                  if (xfer) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end else if (do_push) begin
                  state <= nxt_sub ? SUB : PUSH;
               end else if (cur_sub) begin
                  state <= SUB;
               end
            end
            SUB: begin
               sbox_q <= sub_word(sub_addr);
               state  <= GEN;
            end
            GEN: begin
               if (do_push) begin
                  if (wmod == 3'd0) rcon <= xtime(rcon);
                  state <= nxt_sub ? SUB : PUSH;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_schedule_engine
//  Description : Directed-vector bench for key_schedule_engine using the
//                FIPS-197 AES-128/192/256 expansion examples.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_schedule_engine;

   localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic         start_cmd;
   logic         rdy_cmd;
   int           sel;
   logic         s128, s192, s256;
   logic [127:0] k128;
   logic [191:0] k192;
   logic [255:0] k256;

   logic         b0, v0, l0, d0, b1, v1, l1, d1, b2, v2, l2, d2;
   logic [127:0] rk0, rk1, rk2;
   logic [3:0]   rr0, rr1, rr2;

   logic         mon_busy, mon_v, mon_rl, mon_done;
   logic [127:0] mon_rk;
   logic [3:0]   mon_rr;

   logic [127:0] exp_tab [15];
   bit           exp_known [15];

   int n_checks = 0;
   int n_fail   = 0;

   assign s128 = start_cmd && (sel == 0);
   assign s192 = start_cmd && (sel == 1);
   assign s256 = start_cmd && (sel == 2);

   key_schedule_engine #(.KEY_BITS(128)) dut128 (
      .clk(clk), .reset(reset), .start(s128), .key(k128), .busy(b0), .rkValid(v0),
      .rkReady(rdy_cmd), .roundKey(rk0), .rkRound(rr0), .rkLast(l0), .done(d0));
   key_schedule_engine #(.KEY_BITS(192)) dut192 (
      .clk(clk), .reset(reset), .start(s192), .key(k192), .busy(b1), .rkValid(v1),
      .rkReady(rdy_cmd), .roundKey(rk1), .rkRound(rr1), .rkLast(l1), .done(d1));
   key_schedule_engine #(.KEY_BITS(256)) dut256 (
      .clk(clk), .reset(reset), .start(s256), .key(k256), .busy(b2), .rkValid(v2),
      .rkReady(rdy_cmd), .roundKey(rk2), .rkRound(rr2), .rkLast(l2), .done(d2));

   always_comb begin
      mon_busy = b0; mon_v = v0; mon_rl = l0; mon_done = d0; mon_rk = rk0; mon_rr = rr0;
      case (sel)
         1: begin mon_busy = b1; mon_v = v1; mon_rl = l1; mon_done = d1; mon_rk = rk1; mon_rr = rr1; end
         2: begin mon_busy = b2; mon_v = v2; mon_rl = l2; mon_done = d2; mon_rk = rk2; mon_rr = rr2; end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Edge (counted from the accepted start) after which round r becomes valid
   // with rkReady held high; -1 where no closed form is used.
   function automatic int exp_time(input int s, input int r);
      if (s == 0) return 4 + 5 * r;
      if (s == 2) return (r == 0) ? 4 : (r == 1) ? 8 : 5 * r + 3;
      return -1;
   endfunction

   task automatic set_expect(input int s);
      for (int i = 0; i < 15; i++) begin
         exp_tab[i]   = '0;
         exp_known[i] = 1'b0;
      end
      case (s)
         0: begin
            exp_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
            exp_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
            exp_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
            exp_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
            exp_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
            exp_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            exp_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
            exp_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            exp_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
            exp_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
            exp_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
            for (int i = 0; i <= 10; i++) exp_known[i] = 1'b1;
         end
         1: begin
            exp_tab[0]  = 128'h8e73b0f7da0e6452c810f32b809079e5;
            exp_tab[1]  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
            exp_tab[12] = 128'he98ba06f448c773c8ecc720401002202;
            exp_known[0] = 1'b1; exp_known[1] = 1'b1; exp_known[12] = 1'b1;
         end
         default: begin
            exp_tab[0]  = 128'h603deb1015ca71be2b73aef0857d7781;
            exp_tab[1]  = 128'h1f352c073b6108d72d9810a30914dff4;
            exp_tab[2]  = 128'h9ba354118e6925afa51a8b5f2067fcde;
            exp_tab[14] = 128'hfe4890d1e6188d0b046df344706c631e;
            exp_known[0] = 1'b1; exp_known[1] = 1'b1; exp_known[2] = 1'b1; exp_known[14] = 1'b1;
         end
      endcase
   endtask

   // One full expansion on instance s, following every round key to done.
   task automatic run_exp(input int s, input int nrounds, input bit rand_ready, input bit disturb);
      int           edge_n;
      int           n_xfer;
      bit           seen_done;
      bit           stalled_prev;
      logic [127:0] held_key;
      logic [3:0]   held_rnd;
      sel = s;
      set_expect(s);
      edge_n = 0; n_xfer = 0; seen_done = 1'b0; stalled_prev = 1'b0;
      held_key = '0; held_rnd = '0;
      rdy_cmd   = 1'b1;
      start_cmd = 1'b1;
      tick();                                  // E0
      start_cmd = 1'b0;
      if (disturb) k128 = ~K128;
      check("busy_after_start", mon_busy, 1'b1);
      while (!seen_done && edge_n < 1000) begin
         if (stalled_prev) begin
            check("held_valid", mon_v, 1'b1);
            check("held_key", mon_rk, held_key);
            check("held_round", mon_rr, held_rnd);
         end else if (mon_v) begin
            if (n_xfer < nrounds) begin
               if (exp_known[n_xfer]) check("round_key", mon_rk, exp_tab[n_xfer]);
               check("round_index", mon_rr, n_xfer);
               check("last_flag", mon_rl, (n_xfer == nrounds - 1));
               if (!rand_ready && exp_time(s, n_xfer) >= 0)
                  check("valid_time", edge_n, exp_time(s, n_xfer));
            end else begin
               check("extra_round", n_xfer, nrounds - 1);
            end
            held_key = mon_rk;
            held_rnd = mon_rr;
         end
         if (mon_done) begin
            seen_done = 1'b1;
            check("transfers_at_done", n_xfer, nrounds);
            check("busy_at_done", mon_busy, 1'b0);
            if (!rand_ready && exp_time(s, nrounds - 1) >= 0)
               check("done_time", edge_n, exp_time(s, nrounds - 1) + 1);
         end else begin
            rdy_cmd      = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
            start_cmd    = disturb && (edge_n == 19);
            stalled_prev = mon_v && !rdy_cmd;
            if (mon_v && rdy_cmd) n_xfer++;
            tick();
            edge_n++;
         end
      end
      if (!seen_done) check("timeout_waiting_done", 1'b0, 1'b1);
      start_cmd = 1'b0;
      rdy_cmd   = 1'b1;
      tick();
      check("done_pulse_width", mon_done, 1'b0);
      k128 = K128;
   endtask

   initial begin
      reset = 1'b1; start_cmd = 1'b0; rdy_cmd = 1'b1; sel = 0;
      k128 = K128; k192 = K192; k256 = K256;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("reset_busy",     b0,  1'b0);
      check("reset_valid",    v0,  1'b0);
      check("reset_roundkey", rk0, 128'h0);
      check("reset_round",    rr0, 4'h0);
      check("reset_last",     l0,  1'b0);
      check("reset_done",     d0,  1'b0);

      run_exp(0, 11, 1'b0, 1'b0);   // AES-128, ready high, exact timing
      run_exp(0, 11, 1'b1, 1'b0);   // AES-128, random back-pressure
      run_exp(0, 11, 1'b0, 1'b1);   // AES-128, stray start and key change
      run_exp(1, 13, 1'b0, 1'b0);   // AES-192
      run_exp(2, 15, 1'b0, 1'b0);   // AES-256

      // Abort with reset just after round 3 has transferred.
      sel = 0; set_expect(0);
      rdy_cmd = 1'b1; start_cmd = 1'b1;
      tick();                                  // E0
      start_cmd = 1'b0;
      repeat (19) tick();                      // after E19
      check("pre_reset_valid", v0,  1'b1);
      check("pre_reset_key",   rk0, exp_tab[3]);
      tick();                                  // after E20, round 3 taken
      reset = 1'b1;
      #1;
      check("abort_busy",     b0,  1'b0);
      check("abort_valid",    v0,  1'b0);
      check("abort_roundkey", rk0, 128'h0);
      check("abort_round",    rr0, 4'h0);
      check("abort_last",     l0,  1'b0);
      check("abort_done",     d0,  1'b0);
      tick(); tick();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("no_done_after_abort", d0, 1'b0);
         check("idle_after_abort",    b0, 1'b0);
      end
      start_cmd = 1'b1;
      tick();                                  // E0
      start_cmd = 1'b0;
      repeat (3) tick();
      check("restart_not_valid_e3", v0, 1'b0);
      tick();                                  // after E4
      check("restart_valid_e4", v0,  1'b1);
      check("restart_round0",   rk0, exp_tab[0]);
      check("restart_index0",   rr0, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/key_schedule_engine.md
# key_schedule_engine

Sequential, parametrised AES key-expansion engine supporting 128-, 192- and 256-bit cipher keys. It generates the FIPS-197 word schedule one 32-bit word at a time through four synchronous S-box lookups. It streams the Nr+1 128-bit round keys to the cipher datapath over a valid/ready handshake. It supersedes single-round combinational key generation, so the cipher core no longer has to sequence rounds or constants itself.

## Interface
- KEY_BITS, 128, cipher key length; legal values 128/192/256. Derived values: Nk = KEY_BITS/32 (4/6/8) and Nr = 10/12/14.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request a new expansion; sampled only in IDLE.
- key  in  KEY_BITS  cipher key; key[KEY_BITS-1 -: 32] is w[0]; sampled on the accepted start edge.
- busy  out  1  high from the accepted start until done.
- rkValid  out  1  roundKey/rkRound valid.
- rkReady  in  1  consumer accepts; a transfer occurs on an edge where rkValid && rkReady.
- roundKey  out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}; w[4r] in bits [127:96].
- rkRound  out  4  round index r of roundKey, 0..Nr.
- rkLast  out  1  high with rkValid when r == Nr.
- done  out  1  one-cycle pulse after the final transfer.

## Operation
- Reset values: busy=0, rkValid=0, roundKey=0, rkRound=0, rkLast=0, done=0, FSM=IDLE.
- State: Nk-word sliding window of w[i-Nk..i-1], word index i (0..4(Nr+1)-1), 4-word output assembler with fill count, 8-bit rcon register.
  - The rcon register is reset to 0x01 on start.
  - After each i mod Nk == 0 word, rcon is advanced by xtime (shift left 1, XOR 0x1b on carry out).
- FSM states: IDLE, PUSH, SUB, GEN, DONE.
  - IDLE: start=1 → load window with key, i=0, busy=1 → PUSH.
  - PUSH (for i < Nk): pushes key word w[i] into the assembler.
  - PUSH (for i ≥ Nk): if the word needs SubWord, go to SUB; otherwise compute and push w[i] = w[i-Nk] ^ w[i-1].
  - SubWord is needed when i mod Nk == 0, or when Nk == 8 and i mod 8 == 4.
  - SUB: drives the four S-box addresses, one cycle. The address is RotWord(w[i-1]) for i mod Nk == 0, else w[i-1]. → GEN.
  - GEN: t = sbox output, with t ^= {rcon, 24'h0} when i mod Nk == 0; push w[i] = w[i-Nk] ^ t; advance rcon if applicable → PUSH.
  - After the push of the last word (i = 4Nr+3), the FSM waits for the final transfer, then goes to DONE.
  - DONE: done=1 and busy=0 for one cycle → IDLE.
- Assembler: the fourth push sets rkValid, roundKey, rkRound and rkLast.
- Stall: a push (PUSH or GEN) is blocked while rkValid && !rkReady, and the FSM holds its state. SUB may be issued while stalled.
- On a transfer edge, a push in the same cycle becomes word 0 of the next round key (no bubble). rkValid drops on that edge unless that push completes a round key, which is impossible within one edge.
- Outputs are stable while rkValid && !rkReady.
- start while busy is ignored. key changes after the accepted start have no effect.
- reset asserted mid-expansion aborts immediately with no done pulse. A new start is required.

## Timing
- Edge E0 = accepted start. Key words push at E1..E4, so round 0 is valid after E4.
- Each generated word costs 1 cycle, or 2 cycles if it needs SubWord.
- With rkReady held high:
  - KEY_BITS=128: round r is valid after E(4+5r); round 10 is valid after E54; done pulses after E55.
  - KEY_BITS=256: every round key beyond round 1 contains exactly one SubWord word, so rounds are 5 cycles apart.
- S-box latency is exactly one cycle (synchronous lookup). No combinational path from rkReady to rkValid or roundKey.
- Back-pressure stretches timing cycle-for-cycle and never alters key values.

## Test plan
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, rkReady=1 → round 1 = a0fafe1788542cb123a339392a6c7605 valid after E9; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rkLast=1 after E54; done pulse after E55; exactly 11 transfers.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → round 12 = e98ba06f448c773c8ecc720401002202; 13 transfers; rkRound runs 0..12.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → round 14 = fe4890d1e6188d0b046df344706c631e; 15 transfers.
- Random rkReady (≈30% high), AES-128 vector → identical 11 keys in order; roundKey/rkRound stable whenever rkValid && !rkReady; no dropped or duplicated rounds.
- start pulsed at E20 mid-run, and key changed after E0 → ignored; output matches the first key's schedule.
- reset asserted mid-run (after round 3 transfer) → all outputs 0 on assertion, no done pulse. A new start with the AES-128 vector then yields the correct round 0 after E4.
